// File: rtl/voice_env_mixer_pkg.sv
// -----------------------------------------------------------------------------
// voice_env_mixer_pkg
//   Shared definitions for the voice envelope mixer: the ADSR state encoding
//   used by the per-channel state array and by the adsr_step next-state logic.
// -----------------------------------------------------------------------------
package voice_env_mixer_pkg;

    typedef enum logic [2:0] {
        ADSR_IDLE    = 3'd0,
        ADSR_ATTACK  = 3'd1,
        ADSR_DECAY   = 3'd2,
        ADSR_SUSTAIN = 3'd3,
        ADSR_RELEASE = 3'd4
    } adsr_state_e;

endpackage

// File: rtl/voice_env_mixer_if.sv
// -----------------------------------------------------------------------------
// voice_env_mixer_if
//   Time-multiplexed waveform stream into the mixer and mixed sample out.
//   wave_in      signed sample for the channel named by wave_slot
//   wave_valid   wave_in / wave_slot qualify this cycle
//   wave_slot    one-hot channel id
//   sample_out   signed mixed sample, held between strobes
//   sample_valid one-cycle strobe per completed frame
//   master: stream source / sample sink; slave: the mixer.
// -----------------------------------------------------------------------------
interface voice_env_mixer_if #(
    parameter int WIDTH        = 18,
    parameter int NUM_CHANNELS = 16
);
    logic signed [WIDTH-1:0]   wave_in;
    logic                      wave_valid;
    logic [NUM_CHANNELS-1:0]   wave_slot;
    logic signed [WIDTH-1:0]   sample_out;
    logic                      sample_valid;

    modport master (
        output wave_in,
        output wave_valid,
        output wave_slot,
        input  sample_out,
        input  sample_valid
    );

    modport slave (
        input  wave_in,
        input  wave_valid,
        input  wave_slot,
        output sample_out,
        output sample_valid
    );
endinterface

// File: rtl/voice_env_mixer_adsr_step.sv
// -----------------------------------------------------------------------------
// adsr_step
//   Combinational ADSR next-state / next-level for one channel. A single
//   instance is time-shared across all slots by the mixer.
//   i_state, i_level   current envelope state and level of the slot
//   i_gate             key-held level of the slot
//   i_attack_step      increment per visit in ATTACK
//   i_decay_step       decrement per visit in DECAY
//   i_sustain_lvl      SUSTAIN hold level
//   i_release_step     decrement per visit in RELEASE
//   o_state, o_level   value written back for the slot
// -----------------------------------------------------------------------------
module adsr_step
    import voice_env_mixer_pkg::*;
#(
    parameter int ENV_BITS = 16
) (
    input  adsr_state_e         i_state,
    input  logic [ENV_BITS-1:0] i_level,
    input  logic                i_gate,
    input  logic [ENV_BITS-1:0] i_attack_step,
    input  logic [ENV_BITS-1:0] i_decay_step,
    input  logic [ENV_BITS-1:0] i_sustain_lvl,
    input  logic [ENV_BITS-1:0] i_release_step,
    output adsr_state_e         o_state,
    output logic [ENV_BITS-1:0] o_level
);

    localparam logic [ENV_BITS-1:0] ENV_MAX   = '1;
    localparam logic [ENV_BITS:0]   ENV_MAX_X = {1'b0, ENV_MAX};

    // One extra bit so the attack sum cannot wrap before the ENV_MAX test.
    logic [ENV_BITS:0]          w_up;
    logic [ENV_BITS-1:0]        w_up_sat;
    // Two extra bits so level-decay_step goes negative instead of wrapping.
    logic signed [ENV_BITS+1:0] w_down;
    logic signed [ENV_BITS+1:0] w_sus_x;

    assign w_up     = {1'b0, i_level} + {1'b0, i_attack_step};
    assign w_up_sat = (w_up >= ENV_MAX_X) ? ENV_MAX : w_up[ENV_BITS-1:0];
    assign w_down   = $signed({2'b00, i_level}) - $signed({2'b00, i_decay_step});
    assign w_sus_x  = $signed({2'b00, i_sustain_lvl});

    always_comb begin
        o_state = i_state;
        o_level = i_level;
        case (i_state)
            ADSR_IDLE: begin
                // attack_step never exceeds ENV_MAX, so min() is the step itself.
                if (i_gate) begin
                    o_state = ADSR_ATTACK;
                    o_level = i_attack_step;
                end else begin
                    o_level = '0;
                end
            end
            ADSR_ATTACK: begin
                if (!i_gate) begin
                    o_state = ADSR_RELEASE;
                end else if (w_up >= ENV_MAX_X) begin
                    o_state = ADSR_DECAY;
                    o_level = ENV_MAX;
                end else begin
                    o_level = w_up[ENV_BITS-1:0];
                end
            end
            ADSR_DECAY: begin
                if (!i_gate) begin
                    o_state = ADSR_RELEASE;
                end else if (w_down <= w_sus_x) begin
                    o_state = ADSR_SUSTAIN;
                    o_level = i_sustain_lvl;
                end else begin
                    o_level = w_down[ENV_BITS-1:0];
                end
            end
            ADSR_SUSTAIN: begin
                if (!i_gate) begin
                    o_state = ADSR_RELEASE;
                end else begin
                    o_level = i_sustain_lvl;
                end
            end
            ADSR_RELEASE: begin
                // Retrigger climbs from the current level rather than from 0.
                if (i_gate) begin
                    o_state = ADSR_ATTACK;
                    o_level = w_up_sat;
                end else if (i_level <= i_release_step) begin
                    o_state = ADSR_IDLE;
                    o_level = '0;
                end else begin
                    o_level = i_level - i_release_step;
                end
            end
            default: begin
                o_state = ADSR_IDLE;
                o_level = '0;
            end
        endcase
    end

endmodule

// File: rtl/voice_env_mixer.sv
// -----------------------------------------------------------------------------
// voice_env_mixer
//   Runs one ADSR envelope per channel over a time-multiplexed waveform
//   stream, scales each sample by its envelope and averages all channels into
//   one mixed sample per frame (slots 0..NUM_CHANNELS-1).
//   clk, rst         single clock, synchronous active-high reset
//   bus_if (slave)   wave_in/wave_valid/wave_slot in, sample_out/sample_valid out
//   i_gate           per-channel key-held level
//   i_attack_step    ATTACK increment per frame
//   i_decay_step     DECAY decrement per frame
//   i_sustain_lvl    SUSTAIN level
//   i_release_step   RELEASE decrement per frame
//   o_voice_active   bit i set while channel i is not IDLE (registered)
// Latency: sample_valid rises 3 cycles after the slot NUM_CHANNELS-1 beat.
// -----------------------------------------------------------------------------
module voice_env_mixer
    import voice_env_mixer_pkg::*;
#(
    parameter int WIDTH        = 18,
    parameter int NUM_CHANNELS = 16,
    parameter int ENV_BITS     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    voice_env_mixer_if.slave        bus_if,
    input  logic [NUM_CHANNELS-1:0] i_gate,
    input  logic [ENV_BITS-1:0]     i_attack_step,
    input  logic [ENV_BITS-1:0]     i_decay_step,
    input  logic [ENV_BITS-1:0]     i_sustain_lvl,
    input  logic [ENV_BITS-1:0]     i_release_step,
    output logic [NUM_CHANNELS-1:0] o_voice_active
);

    localparam int CH_BITS = $clog2(NUM_CHANNELS);
    localparam int PROD_W  = WIDTH + ENV_BITS + 1;
    localparam int ACC_W   = WIDTH + CH_BITS;

    // Floor-scale the product back to sample width; |level| < 1.0 so it fits.
    function automatic logic signed [WIDTH-1:0] scale_fn(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] sh;
        sh = p >>> ENV_BITS;
        return sh[WIDTH-1:0];
    endfunction

    // Average over the frame; the sum of NUM_CHANNELS samples divided back fits WIDTH.
    function automatic logic signed [WIDTH-1:0] avg_fn(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> CH_BITS;
        return sh[WIDTH-1:0];
    endfunction

    adsr_state_e             r_state [NUM_CHANNELS];
    logic [ENV_BITS-1:0]     r_level [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_voice_active;

    logic                    w_accept;
    logic [CH_BITS-1:0]      w_idx;
    adsr_state_e             w_nxt_state;
    logic [ENV_BITS-1:0]     w_nxt_level;

    logic signed [WIDTH-1:0]  r_wave_p1;
    logic [ENV_BITS-1:0]      r_level_p1;
    logic                     r_vld_p1;
    logic                     r_last_p1;

    logic signed [PROD_W-1:0] r_prod_p2;
    logic                     r_vld_p2;
    logic                     r_last_p2;

    logic signed [WIDTH-1:0]  w_scaled;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [WIDTH-1:0]  r_sample_out;
    logic                     r_sample_valid;

    // Zero-hot and multi-hot slots are dropped before touching any state.
    assign w_accept = bus_if.wave_valid && $onehot(bus_if.wave_slot);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (bus_if.wave_slot[i]) begin
                w_idx = CH_BITS'(i);
            end
        end
    end

    adsr_step #(
        .ENV_BITS       (ENV_BITS)
    ) u_adsr_step (
        .i_state        (r_state[w_idx]),
        .i_level        (r_level[w_idx]),
        .i_gate         (i_gate[w_idx]),
        .i_attack_step  (i_attack_step),
        .i_decay_step   (i_decay_step),
        .i_sustain_lvl  (i_sustain_lvl),
        .i_release_step (i_release_step),
        .o_state        (w_nxt_state),
        .o_level        (w_nxt_level)
    );

    // ---- Stage 1: envelope read-modify-write and operand capture ----
    // Write-back lands in the same cycle, so a repeated slot sees fresh state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_state[i] <= ADSR_IDLE;
                r_level[i] <= '0;
            end
        end else if (w_accept) begin
            r_state[w_idx] <= w_nxt_state;
            r_level[w_idx] <= w_nxt_level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= w_accept;
            r_last_p1 <= w_accept && (w_idx == CH_BITS'(NUM_CHANNELS - 1));
        end
    end

    always_ff @(posedge clk) begin
        r_wave_p1  <= bus_if.wave_in;
        r_level_p1 <= w_nxt_level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_voice_active <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_voice_active[i] <= (r_state[i] != ADSR_IDLE);
            end
        end
    end

    // ---- Stage 2: sample x envelope multiply ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else begin
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
        end
    end

    always_ff @(posedge clk) begin
        r_prod_p2 <= PROD_W'(r_wave_p1) * PROD_W'($signed({1'b0, r_level_p1}));
    end

    // ---- Stage 3: accumulate, emit on the last slot of the frame ----
    assign w_scaled  = scale_fn(r_prod_p2);
    assign w_acc_sum = r_acc + ACC_W'(w_scaled);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc          <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= r_vld_p2 && r_last_p2;
            if (r_vld_p2) begin
                if (r_last_p2) begin
                    r_sample_out <= avg_fn(w_acc_sum);
                    r_acc        <= '0;
                end else begin
                    r_acc        <= w_acc_sum;
                end
            end
        end
    end

    assign bus_if.sample_out   = r_sample_out;
    assign bus_if.sample_valid = r_sample_valid;
    assign o_voice_active      = r_voice_active;

endmodule

// File: tb/tb_voice_env_mixer.sv
module tb_voice_env_mixer;

    localparam int W  = 18;
    localparam int NC = 4;
    localparam int EB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] gate;
    logic [EB-1:0] att, dec, sus, rel;
    logic [NC-1:0] voice_active;

    always #5 clk = ~clk;

    voice_env_mixer_if #(.WIDTH(W), .NUM_CHANNELS(NC)) bus_if ();

    voice_env_mixer #(
        .WIDTH          (W),
        .NUM_CHANNELS   (NC),
        .ENV_BITS       (EB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_if         (bus_if),
        .i_gate         (gate),
        .i_attack_step  (att),
        .i_decay_step   (dec),
        .i_sustain_lvl  (sus),
        .i_release_step (rel),
        .o_voice_active (voice_active)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_valid  = 0;
    int n_pushed = 0;

    int     exp_q[$];
    int     exp_cyc_q[$];
    int     m_state[NC];
    int     m_level[NC];
    longint m_acc;
    int     mon_e, mon_c;

    always @(posedge clk) cyc++;

    // Scoreboard consumer: every strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (bus_if.sample_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: sample_out=%0d at cycle %0d, no frame pending", bus_if.sample_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                if (int'(bus_if.sample_out) !== mon_e) begin
                    errors++;
                    $display("FAIL sample_value: got %0d expected %0d (cycle %0d)", bus_if.sample_out, mon_e, cyc);
                end
                checks++;
                if (cyc !== mon_c) begin
                    errors++;
                    $display("FAIL sample_latency: strobe at cycle %0d expected cycle %0d", cyc, mon_c);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_state[i] = 0;
            m_level[i] = 0;
        end
        m_acc = 0;
    endtask

    // Reference ADSR + mix for one accepted slot; pushes a frame result on slot NC-1.
    task automatic model_slot(input int ch, input int wave);
        int a, d, s, r, st, lv;
        longint prod;
        a = att; d = dec; s = sus; r = rel;
        st = m_state[ch]; lv = m_level[ch];
        case (st)
            0: if (gate[ch]) begin st = 1; lv = a; end else lv = 0;
            1: if (!gate[ch]) st = 4;
               else if (lv + a >= 65535) begin lv = 65535; st = 2; end
               else lv = lv + a;
            2: if (!gate[ch]) st = 4;
               else if (lv - d <= s) begin lv = s; st = 3; end
               else lv = lv - d;
            3: if (!gate[ch]) st = 4; else lv = s;
            default: if (gate[ch]) begin st = 1; lv = (lv + a > 65535) ? 65535 : lv + a; end
                     else if (lv <= r) begin lv = 0; st = 0; end
                     else lv = lv - r;
        endcase
        m_state[ch] = st;
        m_level[ch] = lv;
        prod  = longint'(wave) * longint'(lv);
        m_acc = m_acc + (prod >>> 16);
        if (ch == NC - 1) begin
            exp_q.push_back(int'(m_acc >>> 2));
            exp_cyc_q.push_back(cyc + 3);
            n_pushed++;
            m_acc = 0;
        end
    endtask

    function automatic logic [NC-1:0] model_active();
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = (m_state[i] != 0);
        return v;
    endfunction

    task automatic drive_slot(input int ch, input int wave);
        @(negedge clk);
        bus_if.wave_valid = 1'b1;
        bus_if.wave_slot  = NC'(1) << ch;
        bus_if.wave_in    = W'(wave);
        model_slot(ch, wave);
    endtask

    task automatic drive_junk(input logic vld, input logic [NC-1:0] slot, input int wave);
        @(negedge clk);
        bus_if.wave_valid = vld;
        bus_if.wave_slot  = slot;
        bus_if.wave_in    = W'(wave);
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus_if.wave_valid = 1'b0;
        bus_if.wave_slot  = '0;
        bus_if.wave_in    = '0;
    endtask

    task automatic run_frame(input int w0, input int wo, input bit junk);
        for (int ch = 0; ch < NC; ch++) begin
            drive_slot(ch, (ch == 0) ? w0 : wo);
            if (junk) begin
                drive_junk(1'b1, '0, 77777);
                drive_junk(1'b1, 4'b0110, -5000);
                drive_junk(1'b0, NC'(1) << ch, 12345);
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 32) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d frames still pending, expected 0", tag, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        int nv;
        rst = 1'b1;
        gate = '0; att = '0; dec = '0; sus = '0; rel = '0;
        bus_if.wave_valid = 1'b0; bus_if.wave_slot = '0; bus_if.wave_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus_if.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_if.sample_valid); end
        checks++;
        if (bus_if.sample_out !== '0) begin errors++; $display("FAIL reset_out: got %0d expected 0", bus_if.sample_out); end
        checks++;
        if (voice_active !== '0) begin errors++; $display("FAIL reset_active: got %b expected 0000", voice_active); end
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            run_frame(32'h0FFFF, 32'h0FFFF, 1'b0);
            go_idle();
            wait_drain("gates_off");
            checks++;
            if (int'(bus_if.sample_out) !== 0) begin errors++; $display("FAIL gates_off_out: got %0d expected 0", bus_if.sample_out); end
            checks++;
            if (voice_active !== 4'b0000) begin errors++; $display("FAIL gates_off_active: got %b expected 0000", voice_active); end
        end
        // Partial frame with a live channel, then reset before the last slot.
        gate = 4'b0010; att = 16'h4000;
        drive_slot(0, 32'h0FFFF);
        drive_slot(1, 32'h0FFFF);
        @(negedge clk);
        rst = 1'b1;
        bus_if.wave_valid = 1'b0; bus_if.wave_slot = '0;
        model_reset();
        nv = n_valid;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gate = '0;
        repeat (8) @(negedge clk);
        checks++;
        if (n_valid !== nv) begin errors++; $display("FAIL midframe_reset_valid: %0d strobes expected 0", n_valid - nv); end
        checks++;
        if (voice_active !== 4'b0000) begin errors++; $display("FAIL midframe_reset_active: got %b expected 0000", voice_active); end
        run_frame(32'h0FFFF, 32'h0FFFF, 1'b0);
        go_idle();
        wait_drain("after_reset");
        checks++;
        if (int'(bus_if.sample_out) !== 0) begin errors++; $display("FAIL after_reset_out: got %0d expected 0 (acc not cleared)", bus_if.sample_out); end
    endtask

    task automatic test_attack();
        int exp_tab[4] = '{4096, 8192, 12288, 16383};
        att = 16'h4000; gate = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            run_frame(65536, 0, 1'b0);
            go_idle();
            wait_drain("attack");
            checks++;
            if (int'(bus_if.sample_out) !== exp_tab[k]) begin errors++; $display("FAIL attack_out[%0d]: got %0d expected %0d", k, bus_if.sample_out, exp_tab[k]); end
        end
        checks++;
        if (voice_active !== 4'b0001) begin errors++; $display("FAIL attack_active: got %b expected 0001", voice_active); end
    endtask

    task automatic test_decay_sustain();
        int e;
        dec = 16'h1000; sus = 16'h8000;
        for (int k = 0; k < 9; k++) begin
            run_frame(65536, 0, 1'b0);
            go_idle();
            wait_drain("decay");
            e = (k < 7) ? (15359 - 1024 * k) : 8192;
            checks++;
            if (int'(bus_if.sample_out) !== e) begin errors++; $display("FAIL decay_out[%0d]: got %0d expected %0d", k, bus_if.sample_out, e); end
        end
        sus = 16'h6000;
        run_frame(65536, 0, 1'b0);
        go_idle();
        wait_drain("sustain_track");
        checks++;
        if (int'(bus_if.sample_out) !== 6144) begin errors++; $display("FAIL sustain_track_out: got %0d expected 6144", bus_if.sample_out); end
        sus = 16'h8000;
        run_frame(65536, 0, 1'b0);
        go_idle();
        wait_drain("sustain_back");
        checks++;
        if (int'(bus_if.sample_out) !== 8192) begin errors++; $display("FAIL sustain_back_out: got %0d expected 8192", bus_if.sample_out); end
    endtask

    task automatic test_release();
        int exp_tab[4] = '{8192, 5120, 2048, 0};
        logic [NC-1:0] va_tab[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        gate = 4'b0000; rel = 16'h3000;
        for (int k = 0; k < 4; k++) begin
            run_frame(65536, 0, 1'b0);
            go_idle();
            wait_drain("release");
            checks++;
            if (int'(bus_if.sample_out) !== exp_tab[k]) begin errors++; $display("FAIL release_out[%0d]: got %0d expected %0d", k, bus_if.sample_out, exp_tab[k]); end
            checks++;
            if (voice_active !== va_tab[k]) begin errors++; $display("FAIL release_active[%0d]: got %b expected %b", k, voice_active, va_tab[k]); end
        end
    endtask

    task automatic test_retrigger();
        int exp_tab[5] = '{8192, 8192, 5120, 2048, 6144};
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin gate = 4'b0001; att = 16'h8000; end
                1: gate = 4'b0000;
                4: begin gate = 4'b0001; att = 16'h4000; end
                default: ;
            endcase
            run_frame(65536, 0, 1'b0);
            go_idle();
            wait_drain("retrigger");
            checks++;
            if (int'(bus_if.sample_out) !== exp_tab[k]) begin errors++; $display("FAIL retrigger_out[%0d]: got %0d expected %0d", k, bus_if.sample_out, exp_tab[k]); end
        end
        checks++;
        if (voice_active !== 4'b0001) begin errors++; $display("FAIL retrigger_active: got %b expected 0001", voice_active); end
    endtask

    task automatic test_full_mix();
        gate = 4'b1111; att = 16'hFFFF; sus = 16'hFFFF; dec = 16'h1000; rel = 16'h3000;
        for (int f = 0; f < 4; f++) run_frame(-131072, -131072, 1'b1);
        go_idle();
        wait_drain("full_mix");
        checks++;
        if (int'(bus_if.sample_out) !== -131070) begin errors++; $display("FAIL full_mix_out: got %0d expected -131070", bus_if.sample_out); end
        checks++;
        if (voice_active !== 4'b1111) begin errors++; $display("FAIL full_mix_active: got %b expected 1111", voice_active); end
    endtask

    task automatic test_back_to_back();
        int wave;
        for (int f = 0; f < 8; f++) begin
            for (int ch = 0; ch < NC; ch++) begin
                @(negedge clk);
                if (ch == 0) begin
                    gate = NC'($urandom_range(0, 15));
                    att  = EB'($urandom_range(0, 65535));
                    dec  = EB'($urandom_range(0, 65535));
                    sus  = EB'($urandom_range(0, 65535));
                    rel  = EB'($urandom_range(0, 65535));
                end
                wave = int'($urandom_range(0, 262143)) - 131072;
                bus_if.wave_valid = 1'b1;
                bus_if.wave_slot  = NC'(1) << ch;
                bus_if.wave_in    = W'(wave);
                model_slot(ch, wave);
            end
        end
        go_idle();
        wait_drain("back_to_back");
        checks++;
        if (voice_active !== model_active()) begin errors++; $display("FAIL b2b_active: got %b expected %b", voice_active, model_active()); end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay_sustain();
        test_release();
        test_retrigger();
        test_full_mix();
        test_back_to_back();
        repeat (6) @(negedge clk);
        checks++;
        if (n_valid !== n_pushed) begin errors++; $display("FAIL strobe_count: got %0d expected %0d", n_valid, n_pushed); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
